// File: rtl/jk_ff_bank_if.sv
// -----------------------------------------------------------------------------
// jk_ff_bank_if
// Groups the control inputs and the status outputs of jk_ff_bank into one
// bundle. The clock and reset stay plain ports on the module.
//
// Signals (slave = the flip-flop bank, master = whoever drives it):
//   EN       master->slave  clock enable for mode-driven updates
//   MODE     master->slave  00=JK, 01=D, 10=T, 11=SR
//   J        master->slave  J / D / T / S input per bit
//   K        master->slave  K / R input per bit
//   LOAD     master->slave  parallel load strobe
//   D_IN     master->slave  parallel load data
//   CLR_CNT  master->slave  clears ACT_CNT, ERR and ERR_BITS
//   Q        slave->master  registered state
//   Qn       slave->master  exact complement of Q
//   CHG      slave->master  per-bit change flags of the last edge
//   ERR      slave->master  sticky forbidden-SR flag
//   ERR_BITS slave->master  sticky per-bit forbidden-SR flags
//   ACT_CNT  slave->master  saturating count of edges on which Q changed
//
// There is no valid/ready handshake: every input is sampled on every rising
// clock edge, and every output is valid one edge after the inputs that caused
// it (Qn follows Q combinationally).
// -----------------------------------------------------------------------------
interface jk_ff_bank_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
);
   logic             EN;
   logic [1:0]       MODE;
   logic [WIDTH-1:0] J;
   logic [WIDTH-1:0] K;
   logic             LOAD;
   logic [WIDTH-1:0] D_IN;
   logic             CLR_CNT;
   logic [WIDTH-1:0] Q;
   logic [WIDTH-1:0] Qn;
   logic [WIDTH-1:0] CHG;
   logic             ERR;
   logic [WIDTH-1:0] ERR_BITS;
   logic [CNT_W-1:0] ACT_CNT;

   modport master (
      output EN, MODE, J, K, LOAD, D_IN, CLR_CNT,
      input  Q, Qn, CHG, ERR, ERR_BITS, ACT_CNT
   );

   modport slave (
      input  EN, MODE, J, K, LOAD, D_IN, CLR_CNT,
      output Q, Qn, CHG, ERR, ERR_BITS, ACT_CNT
   );
endinterface

// File: rtl/jk_ff_bank.sv
// -----------------------------------------------------------------------------
// jk_ff_bank
// Fully synchronous bank of WIDTH JK-style flip-flops with run-time mode
// select (JK / D / T / SR), clock enable, parallel load, per-bit change
// flags, sticky forbidden-SR detection and a saturating activity counter.
//
// Ports:
//   CLK  rising-edge clock, the only clock
//   RST  synchronous active-high reset
//   bus  jk_ff_bank_if.slave: EN, MODE, J, K, LOAD, D_IN, CLR_CNT in;
//        Q, Qn, CHG, ERR, ERR_BITS, ACT_CNT out
//
// Per-edge priority: RST > LOAD > EN > hold.
// -----------------------------------------------------------------------------
module jk_ff_bank #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int               CNT_W     = 8
) (
   input logic         CLK,
   input logic         RST,
   jk_ff_bank_if.slave bus
);

   typedef enum logic [1:0] {
      MODE_JK = 2'b00,
      MODE_D  = 2'b01,
      MODE_T  = 2'b10,
      MODE_SR = 2'b11
   } mode_e;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Registered state
   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] chg_r;
   logic             err_r;
   logic [WIDTH-1:0] err_bits_r;
   logic [CNT_W-1:0] act_cnt_r;

   // Combinational next-state
   logic             mode_upd;     // EN edge without LOAD: mode logic applies
   mode_e            mode;
   logic [WIDTH-1:0] mode_next;    // per-bit result of the selected mode
   logic [WIDTH-1:0] forbid;       // bits with S=R=1 while in SR mode
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] err_set;      // forbidden bits that actually record
   logic             q_changed;
   logic             cnt_inc;

   assign mode     = mode_e'(bus.MODE);
   assign mode_upd = bus.EN && !bus.LOAD;

   // Per-bit mode evaluation. Computed unconditionally; LOAD/EN gating is
   // applied when selecting q_next so that this block stays a pure function
   // of MODE, J, K and the current state.
   always_comb begin
      mode_next = q_r;
      forbid    = '0;
      for (int i = 0; i < WIDTH; i++) begin
         unique case (mode)
            MODE_JK: begin
               unique case ({bus.J[i], bus.K[i]})
                  2'b00:   mode_next[i] = q_r[i];
                  2'b01:   mode_next[i] = 1'b0;
                  2'b10:   mode_next[i] = 1'b1;
                  default: mode_next[i] = ~q_r[i];
               endcase
            end
            MODE_D: begin
               mode_next[i] = bus.J[i];
            end
            MODE_T: begin
               mode_next[i] = bus.J[i] ? ~q_r[i] : q_r[i];
            end
            default: begin
               // SR: the forbidden 11 combination holds the bit and is
               // reported through forbid instead of picking a winner.
               unique case ({bus.J[i], bus.K[i]})
                  2'b00:   mode_next[i] = q_r[i];
                  2'b01:   mode_next[i] = 1'b0;
                  2'b10:   mode_next[i] = 1'b1;
                  default: begin
                     mode_next[i] = q_r[i];
                     forbid[i]    = 1'b1;
                  end
               endcase
            end
         endcase
      end
   end

   // Priority select and side-effect qualifiers
   always_comb begin
      q_next = q_r;
      if (bus.LOAD) begin
         q_next = bus.D_IN;
      end else if (bus.EN) begin
         q_next = mode_next;
      end

      // Errors only record on edges where the SR logic really drives Q.
      err_set = '0;
      if (mode_upd && (mode == MODE_SR)) begin
         err_set = forbid;
      end

      q_changed = (q_next != q_r);
      cnt_inc   = q_changed && (act_cnt_r != CNT_MAX);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         q_r        <= RESET_VAL;
         chg_r      <= '0;
         err_r      <= 1'b0;
         err_bits_r <= '0;
         act_cnt_r  <= '0;
      end else begin
         q_r   <= q_next;
         chg_r <= q_next ^ q_r;

         // CLR_CNT beats both a simultaneous increment and an error set.
         if (bus.CLR_CNT) begin
            act_cnt_r  <= '0;
            err_r      <= 1'b0;
            err_bits_r <= '0;
         end else begin
            if (cnt_inc) begin
               act_cnt_r <= act_cnt_r + CNT_W'(1);
            end
            if (|err_set) begin
               err_r      <= 1'b1;
               err_bits_r <= err_bits_r | err_set;
            end
         end
      end
   end

   // Qn is derived from the single Q register, so it can never disagree
   // with Q the way a cross-coupled latch pair could.
   assign bus.Q        = q_r;
   assign bus.Qn       = ~q_r;
   assign bus.CHG      = chg_r;
   assign bus.ERR      = err_r;
   assign bus.ERR_BITS = err_bits_r;
   assign bus.ACT_CNT  = act_cnt_r;

endmodule

// File: tb/tb_jk_ff_bank.sv
// -----------------------------------------------------------------------------
// tb_jk_ff_bank
// Self-checking bench for jk_ff_bank (WIDTH=8, RESET_VAL=8'hA5, CNT_W=4).
// A behavioural model built from the characteristic equations of each mode
// tracks the expected outputs; scenario tasks compare the DUT against it and
// against fixed values from the test plan.
// -----------------------------------------------------------------------------
module tb_jk_ff_bank;

   localparam int         W     = 8;
   localparam int         CW    = 4;
   localparam logic [W-1:0] RV  = 8'hA5;
   localparam int         CMAX  = (1 << CW) - 1;

   logic CLK;
   logic RST;

   jk_ff_bank_if #(.WIDTH(W), .CNT_W(CW)) bus ();

   jk_ff_bank #(.WIDTH(W), .RESET_VAL(RV), .CNT_W(CW)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus.slave)
   );

   // ---------------- clock ----------------
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // ---------------- model state ----------------
   logic [W-1:0] m_q, m_chg, m_bits;
   logic         m_err;
   int           m_cnt;
   int           tests_run;
   int           tests_failed;
   logic [W-1:0] exp_q[$];   // expected Q sequence for the D-mode scenario

   // Drive one edge's inputs, advance the model, then sample #1 after the edge.
   task automatic drive_edge(input logic rst, input logic load, input logic en,
                             input logic clr, input logic [1:0] mode,
                             input logic [W-1:0] j, input logic [W-1:0] k,
                             input logic [W-1:0] d_in);
      logic [W-1:0] nq, forb;
      RST = rst; bus.LOAD = load; bus.EN = en; bus.CLR_CNT = clr;
      bus.MODE = mode; bus.J = j; bus.K = k; bus.D_IN = d_in;
      if (rst) begin
         m_q = RV; m_chg = '0; m_err = 1'b0; m_bits = '0; m_cnt = 0;
      end else begin
         forb = '0;
         if (load)       nq = d_in;
         else if (!en)   nq = m_q;
         else begin
            case (mode)
               2'b00: nq = (j & ~m_q) | (~k & m_q);        // Q+ = JQ' + K'Q
               2'b01: nq = j;
               2'b10: nq = m_q ^ j;
               default: begin
                  forb = j & k;
                  nq   = ((j | (m_q & ~k)) & ~forb) | (m_q & forb);
               end
            endcase
         end
         m_chg = nq ^ m_q;
         if (clr) begin
            m_cnt = 0; m_err = 1'b0; m_bits = '0;
         end else begin
            if (nq != m_q && m_cnt < CMAX) m_cnt = m_cnt + 1;
            if (forb != '0) begin m_err = 1'b1; m_bits = m_bits | forb; end
         end
         m_q = nq;
      end
      @(posedge CLK);
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      drive_edge(1, 1, 1, 1, 2'b10, 8'hFF, 8'h00, 8'h33);
      drive_edge(1, 0, 0, 0, 2'b00, 8'h00, 8'h00, 8'h00);
      tests_run++;
      if (bus.Q !== 8'hA5) begin tests_failed++; $display("FAIL reset_q: got %h want a5", bus.Q); end
      tests_run++;
      if (bus.Qn !== 8'h5A) begin tests_failed++; $display("FAIL reset_qn: got %h want 5a", bus.Qn); end
      tests_run++;
      if (bus.CHG !== 8'h00 || bus.ERR !== 1'b0 || bus.ERR_BITS !== 8'h00 || bus.ACT_CNT !== 4'd0) begin
         tests_failed++;
         $display("FAIL reset_status: chg=%h err=%b bits=%h cnt=%0d want 00/0/00/0",
                  bus.CHG, bus.ERR, bus.ERR_BITS, bus.ACT_CNT);
      end
   endtask

   task automatic test_jk();
      drive_edge(0, 1, 0, 1, 2'b00, 8'h00, 8'h00, 8'h00);   // Q=00, counter cleared
      drive_edge(0, 0, 1, 0, 2'b00, 8'h0F, 8'h00, 8'h00);
      tests_run++;
      if (bus.Q !== 8'h0F || bus.CHG !== 8'h0F || bus.ACT_CNT !== 4'd1) begin
         tests_failed++;
         $display("FAIL jk_set: q=%h chg=%h cnt=%0d want 0f/0f/1", bus.Q, bus.CHG, bus.ACT_CNT);
      end
      drive_edge(0, 0, 1, 0, 2'b00, 8'hFF, 8'hFF, 8'h00);
      tests_run++;
      if (bus.Q !== 8'hF0 || bus.CHG !== 8'hFF) begin
         tests_failed++;
         $display("FAIL jk_toggle: q=%h chg=%h want f0/ff", bus.Q, bus.CHG);
      end
      drive_edge(0, 0, 1, 0, 2'b00, 8'h00, 8'h00, 8'h00);
      tests_run++;
      if (bus.Q !== 8'hF0 || bus.CHG !== 8'h00 || bus.ACT_CNT !== 4'd2) begin
         tests_failed++;
         $display("FAIL jk_hold: q=%h chg=%h cnt=%0d want f0/00/2", bus.Q, bus.CHG, bus.ACT_CNT);
      end
      drive_edge(0, 0, 1, 0, 2'b00, 8'h00, 8'hC0, 8'h00);
      tests_run++;
      if (bus.Q !== 8'h30 || bus.CHG !== 8'hC0) begin
         tests_failed++;
         $display("FAIL jk_clear: q=%h chg=%h want 30/c0", bus.Q, bus.CHG);
      end
   endtask

   task automatic test_sr_forbidden();
      drive_edge(0, 1, 0, 1, 2'b00, 8'h00, 8'h00, 8'h3C);
      drive_edge(0, 0, 1, 0, 2'b11, 8'h81, 8'h81, 8'h00);
      tests_run++;
      if (bus.Q !== 8'h3C || bus.ERR !== 1'b1 || bus.ERR_BITS !== 8'h81 || bus.ACT_CNT !== 4'd0) begin
         tests_failed++;
         $display("FAIL sr_forbid: q=%h err=%b bits=%h cnt=%0d want 3c/1/81/0",
                  bus.Q, bus.ERR, bus.ERR_BITS, bus.ACT_CNT);
      end
      drive_edge(0, 0, 1, 0, 2'b11, 8'h00, 8'h00, 8'h00);
      tests_run++;
      if (bus.ERR !== 1'b1 || bus.ERR_BITS !== 8'h81) begin
         tests_failed++;
         $display("FAIL sr_sticky: err=%b bits=%h want 1/81", bus.ERR, bus.ERR_BITS);
      end
      drive_edge(0, 0, 1, 0, 2'b11, 8'h02, 8'h04, 8'h00);   // set bit1, clear bit2
      tests_run++;
      if (bus.Q !== 8'h3A) begin tests_failed++; $display("FAIL sr_setclr: got %h want 3a", bus.Q); end
      drive_edge(0, 0, 0, 1, 2'b00, 8'h00, 8'h00, 8'h00);
      tests_run++;
      if (bus.ERR !== 1'b0 || bus.ERR_BITS !== 8'h00) begin
         tests_failed++;
         $display("FAIL sr_clr: err=%b bits=%h want 0/00", bus.ERR, bus.ERR_BITS);
      end
      // Forbidden input while disabled records nothing
      drive_edge(0, 0, 0, 0, 2'b11, 8'hFF, 8'hFF, 8'h00);
      tests_run++;
      if (bus.ERR !== 1'b0 || bus.Q !== 8'h3A) begin
         tests_failed++;
         $display("FAIL sr_disabled: err=%b q=%h want 0/3a", bus.ERR, bus.Q);
      end
      // Clear wins over a simultaneous error set
      drive_edge(0, 0, 1, 1, 2'b11, 8'h10, 8'h10, 8'h00);
      tests_run++;
      if (bus.ERR !== 1'b0 || bus.ERR_BITS !== 8'h00) begin
         tests_failed++;
         $display("FAIL sr_clr_wins: err=%b bits=%h want 0/00", bus.ERR, bus.ERR_BITS);
      end
   endtask

   task automatic test_priority();
      drive_edge(0, 1, 1, 0, 2'b10, 8'hFF, 8'h00, 8'hC3);
      tests_run++;
      if (bus.Q !== 8'hC3) begin tests_failed++; $display("FAIL prio_load: got %h want c3", bus.Q); end
      drive_edge(1, 1, 1, 0, 2'b10, 8'hFF, 8'h00, 8'h0F);
      tests_run++;
      if (bus.Q !== RV || bus.ACT_CNT !== 4'd0) begin
         tests_failed++;
         $display("FAIL prio_rst: q=%h cnt=%0d want a5/0", bus.Q, bus.ACT_CNT);
      end
      drive_edge(0, 0, 0, 0, 2'b10, 8'hFF, 8'h00, 8'h00);
      tests_run++;
      if (bus.Q !== RV || bus.CHG !== 8'h00) begin
         tests_failed++;
         $display("FAIL prio_hold: q=%h chg=%h want a5/00", bus.Q, bus.CHG);
      end
   endtask

   task automatic test_saturation();
      logic prev0;
      drive_edge(0, 0, 0, 1, 2'b00, 8'h00, 8'h00, 8'h00);
      for (int i = 0; i < 20; i++) begin
         prev0 = bus.Q[0];
         drive_edge(0, 0, 1, 0, 2'b10, 8'h01, 8'h00, 8'h00);
         tests_run++;
         if (bus.ACT_CNT !== CW'((i + 1 > CMAX) ? CMAX : i + 1) || bus.Q[0] !== ~prev0) begin
            tests_failed++;
            $display("FAIL sat_step%0d: cnt=%0d q0=%b want %0d/%b", i, bus.ACT_CNT, bus.Q[0],
                     (i + 1 > CMAX) ? CMAX : i + 1, ~prev0);
         end
      end
      drive_edge(0, 0, 1, 1, 2'b10, 8'h01, 8'h00, 8'h00);
      tests_run++;
      if (bus.ACT_CNT !== 4'd0 || bus.CHG !== 8'h01) begin
         tests_failed++;
         $display("FAIL sat_clr: cnt=%0d chg=%h want 0/01", bus.ACT_CNT, bus.CHG);
      end
   endtask

   task automatic test_d_mode();
      logic [W-1:0] jv;
      for (int i = 0; i < 100; i++) begin
         jv = W'($urandom_range(0, 255));
         exp_q.push_back(jv);
         drive_edge(0, 0, 1, 0, 2'b01, jv, W'($urandom_range(0, 255)), 8'h00);
         tests_run++;
         if (bus.Q !== exp_q[0] || bus.Qn !== ~exp_q[0]) begin
            tests_failed++;
            $display("FAIL d_mode%0d: q=%h qn=%h want %h/%h", i, bus.Q, bus.Qn, exp_q[0], ~exp_q[0]);
         end
         void'(exp_q.pop_front());
      end
   endtask

   task automatic test_random_mix();
      for (int i = 0; i < 300; i++) begin
         drive_edge(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                    2'($urandom_range(0, 3)), W'($urandom), W'($urandom), W'($urandom));
         tests_run++;
         if (bus.Q !== m_q || bus.Qn !== ~m_q || bus.CHG !== m_chg || bus.ERR !== m_err ||
             bus.ERR_BITS !== m_bits || bus.ACT_CNT !== CW'(m_cnt)) begin
            tests_failed++;
            $display("FAIL mix%0d: q=%h qn=%h chg=%h err=%b bits=%h cnt=%0d want %h/%h/%h/%b/%h/%0d",
                     i, bus.Q, bus.Qn, bus.CHG, bus.ERR, bus.ERR_BITS, bus.ACT_CNT,
                     m_q, ~m_q, m_chg, m_err, m_bits, m_cnt);
         end
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      tests_run = 0; tests_failed = 0;
      RST = 1'b1; bus.EN = 1'b0; bus.MODE = 2'b00; bus.J = '0; bus.K = '0;
      bus.LOAD = 1'b0; bus.D_IN = '0; bus.CLR_CNT = 1'b0;
      m_q = RV; m_chg = '0; m_err = 1'b0; m_bits = '0; m_cnt = 0;
      test_reset();
      test_jk();
      test_sr_forbidden();
      test_priority();
      test_saturation();
      test_d_mode();
      test_random_mix();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
